// File: rtl/gp_cmd_fetch.sv
// Command-fetch controller: reads GP command words from memory into a small FIFO
// and streams them to the drawing engine until a stop word (opcode 8'h00) arrives.
module gp_cmd_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [31:0]       cfg_wdata,
  output logic              busy,
  output logic [31:0]       frame_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              cmd_valid,
  output logic [31:0]       cmd_data,
  input  logic              cmd_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              is_stop;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic              space_next;
  logic              code_write;
  logic [ADDR_W-1:0] code_ptr;
  logic [ADDR_W-1:0] ptr_inc;

  // The byte offset of the code pointer is dropped; only word addresses are fetched.
  logic cfg_byte_offset_unused;
  assign cfg_byte_offset_unused = ^cfg_wdata[1:0];

  always_comb begin
    is_stop     = (mem_rdata[31:24] == 8'h00);
    push        = (state == WAIT) && mem_rvalid && !is_stop;
    pop         = cmd_valid && cmd_ready;
    count_next  = count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_next = rd_ptr + PTR_W'(pop);
    // With at most one read outstanding, and none outside WAIT, space is simply count < depth.
    space_next  = (count_next < DEPTH_C);
    code_write  = cfg_we && !cfg_sel && (cfg_wdata != 32'h0);
    code_ptr    = ADDR_W'(cfg_wdata[31:2]);
    ptr_inc     = ptr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      frame_base <= 32'h0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      cmd_valid  <= 1'b0;
      cmd_data   <= 32'h0;
    end else begin
      if (cfg_we && cfg_sel) begin
        frame_base <= cfg_wdata;
      end

      count  <= count_next;
      rd_ptr <= rd_ptr_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      // The head register takes the incoming word directly when it lands in an empty slot.
      cmd_valid <= (count_next != '0);
      if (count_next == '0) begin
        cmd_data <= 32'h0;
      end else if (push && ((count - CNT_W'(pop)) == '0)) begin
        cmd_data <= mem_rdata;
      end else begin
        cmd_data <= fifo_mem[rd_ptr_next];
      end

      case (state)
        IDLE: begin
          mem_req <= 1'b0;
          if (code_write) begin
            ptr      <= code_ptr;
            mem_addr <= code_ptr;
            mem_req  <= space_next;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          mem_addr <= ptr;
          if (mem_req && mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end else begin
            mem_req <= space_next;
          end
        end

        WAIT: begin
          mem_req <= 1'b0;
          if (mem_rvalid) begin
            if (is_stop) begin
              state <= DRAIN;
            end else begin
              ptr      <= ptr_inc;
              mem_addr <= ptr_inc;
              mem_req  <= space_next;
              state    <= REQ;
            end
          end
        end

        DRAIN: begin
          mem_req <= 1'b0;
          if (count == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gp_cmd_fetch.sv
// Directed bench for gp_cmd_fetch: config-port vector table plus hand-written
// fetch, backpressure, grant-stall, restart, wrap and async-reset sequences.
module tb_gp_cmd_fetch;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic        cfg_sel;
  logic [31:0] cfg_wdata;
  logic        busy;
  logic [31:0] frame_base;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_model [int unsigned];
  logic [29:0] gnt_log [$];
  logic [31:0] got [$];
  int          stall_cnt   = 0;
  logic        hold_rvalid = 1'b0;
  logic        pending     = 1'b0;
  logic [29:0] pend_addr   = '0;

  typedef struct {
    logic        we;
    logic        sel;
    logic [31:0] wdata;
    logic        exp_busy;
    logic [31:0] exp_frame;
    logic        exp_req;
  } vec_t;

  vec_t vecs [6];

  gp_cmd_fetch #(.FIFO_DEPTH(4), .ADDR_W(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .busy       (busy),
    .frame_base (frame_base),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] read_mem(input logic [29:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return 32'h0;
  endfunction

  // Memory responder: grant decided just after an edge, data returned one cycle after the grant.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (pending && !hold_rvalid) begin
        mem_rvalid = 1'b1;
        mem_rdata  = read_mem(pend_addr);
        pending    = 1'b0;
      end
      mem_gnt = 1'b0;
      if (mem_req && !pending) begin
        if (stall_cnt > 0) begin
          stall_cnt = stall_cnt - 1;
        end else begin
          mem_gnt   = 1'b1;
          pending   = 1'b1;
          pend_addr = mem_addr;
          gnt_log.push_back(mem_addr);
        end
      end
    end
  end

  // Engine side: record every word actually handed over.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && cmd_valid && cmd_ready) got.push_back(cmd_data);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    cfg_we    = v.we;
    cfg_sel   = v.sel;
    cfg_wdata = v.wdata;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (busy && n < max_cycles) begin
      step();
      n++;
    end
    check_output({name, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_grants(input int target, input int max_cycles, input string name);
    int n = 0;
    while (gnt_log.size() < target && n < max_cycles) begin
      step();
      n++;
    end
    check_output(name, gnt_log.size(), target);
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp_words [$]);
    check_output({name, "_count"}, got.size(), exp_words.size());
    for (int i = 0; i < exp_words.size(); i++) begin
      check_output($sformatf("%s_word%0d", name, i),
                   (i < got.size()) ? got[i] : 32'hxxxxxxxx, exp_words[i]);
    end
  endtask

  initial begin
    logic [31:0] exp_words [$];

    vecs[0] = '{we: 1'b0, sel: 1'b1, wdata: 32'hDEAD_BEEF, exp_busy: 1'b0, exp_frame: 32'h0,         exp_req: 1'b0};
    vecs[1] = '{we: 1'b1, sel: 1'b1, wdata: 32'h1040_0000, exp_busy: 1'b0, exp_frame: 32'h1040_0000, exp_req: 1'b0};
    vecs[2] = '{we: 1'b1, sel: 1'b0, wdata: 32'h0000_0000, exp_busy: 1'b0, exp_frame: 32'h1040_0000, exp_req: 1'b0};
    vecs[3] = '{we: 1'b0, sel: 1'b0, wdata: 32'h1900_0000, exp_busy: 1'b0, exp_frame: 32'h1040_0000, exp_req: 1'b0};
    vecs[4] = '{we: 1'b1, sel: 1'b1, wdata: 32'h0000_0004, exp_busy: 1'b0, exp_frame: 32'h0000_0004, exp_req: 1'b0};
    vecs[5] = '{we: 1'b1, sel: 1'b1, wdata: 32'h1040_0000, exp_busy: 1'b0, exp_frame: 32'h1040_0000, exp_req: 1'b0};

    mem_model[32'h0640_0000] = 32'h02FF_FFFF;
    mem_model[32'h0640_0001] = 32'h0123_0124;
    mem_model[32'h0640_0002] = 32'h00AA_00BB;
    for (int i = 0; i < 10; i++) mem_model[32'h0010_0000 + i] = 32'h1000_0000 + i;
    mem_model[32'h0020_0000] = 32'h0500_0001;
    mem_model[32'h0000_0200] = 32'hA000_0001;
    mem_model[32'h0000_0201] = 32'hA000_0002;
    mem_model[32'h0000_0202] = 32'hA000_0003;
    mem_model[32'h3FFF_FFFF] = 32'h7700_0000;
    mem_model[32'h0000_0300] = 32'h1111_1111;

    rst       = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_wdata = 32'h0;
    cmd_ready = 1'b1;
    repeat (3) step();

    $display("[TB] reset state");
    check_output("rst_busy",       {31'h0, busy},      32'h0);
    check_output("rst_mem_req",    {31'h0, mem_req},   32'h0);
    check_output("rst_mem_addr",   {2'b0, mem_addr},   32'h0);
    check_output("rst_cmd_valid",  {31'h0, cmd_valid}, 32'h0);
    check_output("rst_cmd_data",   cmd_data,           32'h0);
    check_output("rst_frame_base", frame_base,         32'h0);
    rst = 1'b1;
    step();

    $display("[TB] config vector table");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_busy", i),  {31'h0, busy},    {31'h0, vecs[i].exp_busy});
      check_output($sformatf("vec%0d_frame", i), frame_base,       vecs[i].exp_frame);
      check_output($sformatf("vec%0d_req", i),   {31'h0, mem_req}, {31'h0, vecs[i].exp_req});
    end

    $display("[TB] basic fetch");
    got.delete(); gnt_log.delete();
    cmd_ready = 1'b1;
    cfg_write(1'b0, 32'h1900_0000);
    check_output("basic_busy",     {31'h0, busy},    32'h1);
    check_output("basic_req",      {31'h0, mem_req}, 32'h1);
    check_output("basic_addr",     {2'b0, mem_addr}, 32'h0640_0000);
    wait_idle(100, "basic");
    exp_words = '{32'h02FF_FFFF, 32'h0123_0124};
    check_stream("basic", exp_words);
    check_output("basic_frame",    frame_base,         32'h1040_0000);
    check_output("basic_valid_end", {31'h0, cmd_valid}, 32'h0);

    $display("[TB] backpressure");
    got.delete(); gnt_log.delete();
    cmd_ready = 1'b0;
    cfg_write(1'b0, 32'h0040_0000);
    repeat (40) step();
    check_output("bp_grants",  gnt_log.size(),     32'd4);
    check_output("bp_req_low", {31'h0, mem_req},   32'h0);
    check_output("bp_valid",   {31'h0, cmd_valid}, 32'h1);
    check_output("bp_head",    cmd_data,           32'h1000_0000);
    check_output("bp_busy",    {31'h0, busy},      32'h1);
    cmd_ready = 1'b1;
    wait_idle(200, "bp");
    exp_words.delete();
    for (int i = 0; i < 10; i++) exp_words.push_back(32'h1000_0000 + i);
    check_stream("bp", exp_words);
    check_output("bp_total_grants", gnt_log.size(), 32'd11);

    $display("[TB] grant stall");
    got.delete(); gnt_log.delete();
    stall_cnt = 5;
    cfg_write(1'b0, 32'h0080_0000);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output($sformatf("stall_req%0d", i),  {31'h0, mem_req}, 32'h1);
      check_output($sformatf("stall_addr%0d", i), {2'b0, mem_addr}, 32'h0020_0000);
      @(posedge clk);
      #1;
    end
    wait_idle(100, "stall");
    check_output("stall_grants", gnt_log.size(), 32'd2);
    check_output("stall_first_addr", (gnt_log.size() > 0) ? {2'b0, gnt_log[0]} : 32'hxxxxxxxx, 32'h0020_0000);
    exp_words = '{32'h0500_0001};
    check_stream("stall", exp_words);

    $display("[TB] ignored restart");
    got.delete(); gnt_log.delete();
    cfg_write(1'b0, 32'h0000_0800);
    step();
    cfg_write(1'b0, 32'h2000_0000);
    wait_idle(100, "restart");
    check_output("restart_grants", gnt_log.size(), 32'd4);
    check_output("restart_last_addr",
                 (gnt_log.size() == 4) ? {2'b0, gnt_log[3]} : 32'hxxxxxxxx, 32'h0000_0203);
    exp_words = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    check_stream("restart", exp_words);
    cfg_write(1'b0, 32'h0000_0000);
    check_output("zero_code_busy", {31'h0, busy},    32'h0);
    check_output("zero_code_req",  {31'h0, mem_req}, 32'h0);

    $display("[TB] address wrap");
    got.delete(); gnt_log.delete();
    cfg_write(1'b0, 32'hFFFF_FFFC);
    check_output("wrap_first_addr", {2'b0, mem_addr}, 32'h3FFF_FFFF);
    wait_grants(2, 50, "wrap_grants");
    check_output("wrap_next_addr",
                 (gnt_log.size() >= 2) ? {2'b0, gnt_log[1]} : 32'hxxxxxxxx, 32'h0);
    wait_idle(100, "wrap");
    exp_words = '{32'h7700_0000};
    check_stream("wrap", exp_words);

    $display("[TB] async reset in WAIT");
    got.delete(); gnt_log.delete();
    hold_rvalid = 1'b1;
    cfg_write(1'b0, 32'h0000_0C00);
    wait_grants(1, 50, "arst_grant");
    step();
    check_output("arst_busy_before", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("arst_busy",  {31'h0, busy},      32'h0);
    check_output("arst_req",   {31'h0, mem_req},   32'h0);
    check_output("arst_valid", {31'h0, cmd_valid}, 32'h0);
    step();
    rst = 1'b1;
    hold_rvalid = 1'b0;
    repeat (4) step();
    check_output("arst_late_valid", {31'h0, cmd_valid}, 32'h0);
    check_output("arst_late_busy",  {31'h0, busy},      32'h0);
    check_output("arst_late_words", got.size(),         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
